// File: rtl/sequenceur_de.sv
// Dice-roller controller: debounced buttons, die selection, roll sequencing (scramble, slow-down, latched result).
// Latency: a press is seen 2 sync + DEB_CYCLES + 1 cycles after the edge; no backpressure, outputs registered except min_de/max_de.
module sequenceur_de #(
    parameter int DEB_CYCLES      = 500000,
    parameter int MIN_ROLL_CYCLES = 25000000,
    parameter int PERIODE_AFF     = 2500000,
    parameter int SETTLE_STEPS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       suivant_n,
    input  logic       lancer_n,
    output logic [2:0] sel_idx,
    output logic [6:0] min_de,
    output logic [6:0] max_de,
    output logic [6:0] valeur,
    output logic       res_valide,
    output logic       en_cours
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2((PERIODE_AFF << SETTLE_STEPS) + 1);
    localparam int DW = $clog2(MIN_ROLL_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST    = CW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DUR_MAX     = DW'(MIN_ROLL_CYCLES);
    localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_STEPS);

    typedef enum logic [1:0] {ATTENTE, ROULE, RALENTI, AFFICHE} etat_t;

    // Index 0 = suivant, index 1 = lancer.
    logic [1:0]    sync1, sync2, deb, press;
    logic [CW-1:0] deb_cnt [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            deb        <= 2'b11;
            press      <= 2'b00;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1 <= {lancer_n, suivant_n};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                    press[i]   <= deb[i];   // pulse only on the 1 -> 0 (press) edge
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic p_suiv, p_lanc, lanc_relache;
    assign p_suiv       = press[0];
    assign p_lanc       = press[1];
    assign lanc_relache = deb[1];

    assign min_de = 7'd1;
    always_comb begin
        case (sel_idx)
            3'd0:    max_de = 7'd4;
            3'd1:    max_de = 7'd6;
            3'd2:    max_de = 7'd8;
            3'd3:    max_de = 7'd10;
            3'd4:    max_de = 7'd12;
            3'd5:    max_de = 7'd20;
            3'd6:    max_de = 7'd100;
            default: max_de = 7'd4;
        endcase
    end

    etat_t         etat, etat_n;
    logic [2:0]    sel_n, sel_plus;
    logic [6:0]    val_n, face, face_n;
    logic          res_n, en_n;
    logic [TW-1:0] tick, tick_n, tick_sat, tick_lim;
    logic [DW-1:0] dur, dur_n, dur_sat;
    logic [3:0]    step, step_n;

    assign sel_plus = (sel_idx == 3'd6) ? 3'd0 : sel_idx + 3'd1;
    assign tick_sat = (&tick) ? tick : tick + 1'b1;
    assign dur_sat  = (dur == DUR_MAX) ? dur : dur + 1'b1;
    // step is 0 in ROULE, k in RALENTI, so one limit serves both phases.
    assign tick_lim = TW'((PERIODE_AFF << step) - 1);

    always_comb begin
        etat_n = etat;
        sel_n  = sel_idx;
        val_n  = valeur;
        res_n  = res_valide;
        tick_n = tick;
        dur_n  = dur;
        step_n = step;
        case (etat)
            ATTENTE: begin
                val_n = '0;
                if (p_lanc) begin
                    etat_n = ROULE;
                    tick_n = '0;
                    dur_n  = '0;
                    step_n = '0;
                end else if (p_suiv) begin
                    sel_n = sel_plus;
                end
            end
            ROULE: begin
                tick_n = tick_sat;
                dur_n  = dur_sat;
                if (tick == tick_lim) begin
                    val_n  = face;
                    tick_n = '0;
                end
                if (dur >= DUR_MAX && lanc_relache) begin
                    etat_n = RALENTI;
                    tick_n = '0;
                    step_n = 4'd1;
                end
            end
            RALENTI: begin
                tick_n = tick_sat;
                if (tick == tick_lim) begin
                    val_n  = face;
                    tick_n = '0;
                    if (step == SETTLE_LAST) begin
                        etat_n = AFFICHE;
                        res_n  = 1'b1;
                    end else begin
                        step_n = step + 4'd1;
                    end
                end
            end
            AFFICHE: begin
                if (p_lanc) begin
                    etat_n = ROULE;
                    res_n  = 1'b0;
                    tick_n = '0;
                    dur_n  = '0;
                    step_n = '0;
                end else if (p_suiv) begin
                    etat_n = ATTENTE;
                    sel_n  = sel_plus;
                    val_n  = '0;
                    res_n  = 1'b0;
                end
            end
            default: etat_n = ATTENTE;
        endcase
        en_n = (etat_n == ROULE) || (etat_n == RALENTI);
        if (sel_n != sel_idx)    face_n = 7'd1;
        else if (face >= max_de) face_n = 7'd1;
        else                     face_n = face + 7'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            etat       <= ATTENTE;
            sel_idx    <= '0;
            valeur     <= '0;
            res_valide <= 1'b0;
            en_cours   <= 1'b0;
            tick       <= '0;
            dur        <= '0;
            step       <= '0;
            face       <= 7'd1;
        end else begin
            etat       <= etat_n;
            sel_idx    <= sel_n;
            valeur     <= val_n;
            res_valide <= res_n;
            en_cours   <= en_n;
            tick       <= tick_n;
            dur        <= dur_n;
            step       <= step_n;
            face       <= face_n;
        end
    end

endmodule
